// File: rtl/lfsr_stim_gen.sv
// lfsr_stim_gen: Fibonacci LFSR beat generator (RAW / ADDR / BURST / WALK) on a valid/ready port.
// Define LFSR_LOCKUP_DET_EN to enable zero-state recovery and the sticky lockup flag.
module lfsr_stim_gen #(
    parameter int          WIDTH        = 64,
    parameter logic [63:0] TAPS         = 64'hD800000000000000,
    parameter logic [63:0] SEED_DEFAULT = 64'h1,
    parameter int          OUT_W        = 64,
    parameter int          ADDR_W       = 27,
    parameter int          BURST_LEN    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              seed_load,
    input  logic [WIDTH-1:0]  seed,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] addr_mask,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out,
    output logic              burst_last,
    output logic [31:0]       word_cnt,
    output logic              lockup
);

    localparam int IDX_W = $clog2(BURST_LEN);

    localparam logic [1:0] MODE_RAW   = 2'd0;
    localparam logic [1:0] MODE_ADDR  = 2'd1;
    localparam logic [1:0] MODE_BURST = 2'd2;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [WIDTH-1:0] TAP_MASK = TAPS[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED_RST = SEED_DEFAULT[WIDTH-1:0];
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BURST_LEN - 1);

    logic [WIDTH-1:0]  state_q, state_d;
    logic [OUT_W-1:0]  out_q, out_d;
    logic [OUT_W-1:0]  walk_q, walk_d;
    logic              out_valid_q, out_valid_d;
    logic              burst_last_q, burst_last_d;
    logic [31:0]       word_cnt_q, word_cnt_d;
    logic [IDX_W-1:0]  beat_idx_q, beat_idx_d;
    logic [0:0]        fsm_q, fsm_d;
    logic              accept;
    logic              slot;
    logic              reload;
    logic              fb;
    logic [1:0]        eff_mode;
    logic [ADDR_W-1:0] addr_bits;

`ifdef LFSR_LOCKUP_DET_EN
    logic lockup_q, lockup_d;

    // An all-zero state is replaced by the reset seed; that cycle produces no beat.
    assign reload = !seed_load && (state_q == '0);

    always_comb begin
        lockup_d = lockup_q;
        if (seed_load && (seed != '0)) begin
            lockup_d = 1'b0;
        end else if (reload) begin
            lockup_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lockup_q <= 1'b0;
        end else begin
            lockup_q <= lockup_d;
        end
    end

    assign lockup = lockup_q;
`else
    assign reload = 1'b0;
    assign lockup = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        burst_last_d = burst_last_q;
        word_cnt_d   = word_cnt_q;
        beat_idx_d   = beat_idx_q;
        walk_d       = walk_q;
        fsm_d        = fsm_q;

        accept = out_valid_q && out_ready;
        // A nonzero beat index means a burst is in flight, so mode stays frozen at BURST.
        eff_mode = (beat_idx_q != '0) ? MODE_BURST : mode;
        slot = (fsm_q == ST_RUN) && enable && !seed_load && !reload
               && (!out_valid_q || out_ready);
        fb = ^(state_q & TAP_MASK);
        addr_bits = state_q[ADDR_W-1:0] & addr_mask;
        addr_bits[2:0] = 3'b000;

        case (fsm_q)
            ST_IDLE: if (enable) fsm_d = ST_RUN;
            default: if (!enable && !out_valid_q) fsm_d = ST_IDLE;
        endcase

        if (accept) begin
            out_valid_d = 1'b0;
            word_cnt_d  = word_cnt_q + 32'd1;
        end

        if (seed_load) begin
            state_d    = seed;
            beat_idx_d = '0;
            walk_d     = OUT_W'(1);
        end else if (slot) begin
            out_valid_d  = 1'b1;
            burst_last_d = 1'b0;
            state_d      = {state_q[WIDTH-2:0], fb};
            case (eff_mode)
                MODE_RAW: out_d = state_q[OUT_W-1:0];
                MODE_ADDR: out_d = OUT_W'(addr_bits);
                MODE_BURST: begin
                    out_d        = state_q[OUT_W-1:0];
                    burst_last_d = (beat_idx_q == IDX_LAST);
                    beat_idx_d   = beat_idx_q + IDX_W'(1);
                end
                default: begin
                    out_d   = walk_q;
                    walk_d  = {walk_q[OUT_W-2:0], walk_q[OUT_W-1]};
                    state_d = state_q;
                end
            endcase
        end else if (reload) begin
            state_d = SEED_RST;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= SEED_RST;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            burst_last_q <= 1'b0;
            word_cnt_q   <= '0;
            beat_idx_q   <= '0;
            walk_q       <= OUT_W'(1);
            fsm_q        <= ST_IDLE;
        end else begin
            state_q      <= state_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            burst_last_q <= burst_last_d;
            word_cnt_q   <= word_cnt_d;
            beat_idx_q   <= beat_idx_d;
            walk_q       <= walk_d;
            fsm_q        <= fsm_d;
        end
    end

    assign out        = out_q;
    assign out_valid  = out_valid_q;
    assign burst_last = burst_last_q;
    assign word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_lfsr_stim_gen.sv
// tb_lfsr_stim_gen: directed bench for lfsr_stim_gen with a beat scoreboard.
// An 8-bit instance covers the full-period sequence; a 64-bit instance covers the rest.
module tb_lfsr_stim_gen;

    localparam logic [1:0] RAW   = 2'd0;
    localparam logic [1:0] ADDR  = 2'd1;
    localparam logic [1:0] BURST = 2'd2;
    localparam logic [1:0] WALK  = 2'd3;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        seed_load = 1'b0;
    logic        out_ready = 1'b0;
    logic [63:0] seed = '0;
    logic [1:0]  mode = RAW;
    logic [26:0] addr_mask = '1;
    logic        sel64 = 1'b0;

    logic [7:0]  o8;
    logic        v8, bl8, lk8;
    logic [31:0] wc8;
    logic [63:0] o64;
    logic        v64, bl64, lk64;
    logic [31:0] wc64;

    int checks = 0;
    int passed = 0;
    int failed = 0;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    lfsr_stim_gen #(
        .WIDTH(8), .TAPS(64'hB8), .SEED_DEFAULT(64'h1),
        .OUT_W(8), .ADDR_W(8), .BURST_LEN(8)
    ) dut8 (
        .clk(clk), .reset(reset), .enable(enable), .seed_load(seed_load),
        .seed(seed[7:0]), .mode(mode), .addr_mask(addr_mask[7:0]),
        .out_valid(v8), .out_ready(out_ready), .out(o8),
        .burst_last(bl8), .word_cnt(wc8), .lockup(lk8)
    );

    lfsr_stim_gen dut64 (
        .clk(clk), .reset(reset), .enable(enable), .seed_load(seed_load),
        .seed(seed), .mode(mode), .addr_mask(addr_mask),
        .out_valid(v64), .out_ready(out_ready), .out(o64),
        .burst_last(bl64), .word_cnt(wc64), .lockup(lk64)
    );

    function automatic logic [63:0] adv64(input logic [63:0] s);
        return {s[62:0], ^(s & 64'hD800_0000_0000_0000)};
    endfunction

    function automatic logic [63:0] adv8(input logic [63:0] s);
        return {56'd0, s[6:0], ^(s[7:0] & 8'hB8)};
    endfunction

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        enable = 1'b0;
        seed_load = 1'b0;
        out_ready = 1'b0;
        mode = RAW;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic apply_stimulus(input logic [63:0] s, input logic [1:0] m, input logic r);
        @(posedge clk);
        #1;
        seed = s;
        mode = m;
        out_ready = r;
        enable = 1'b1;
        seed_load = 1'b1;
        @(posedge clk);
        #1 seed_load = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check_output("drain_left", 64'(exp_q.size()), 64'd0);
        #1;
        out_ready = 1'b0;
        enable = 1'b0;
    endtask

    task automatic wait_wc(input logic [31:0] target, input int budget);
        int n = 0;
        while (wc64 != target && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_output("wait_wc", 64'(wc64), 64'(target));
    endtask

    task automatic wait_valid64(input int budget);
        int n = 0;
        while (!v64 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_output("wait_valid", 64'(v64), 64'd1);
    endtask

    // Every accepted beat is matched against the next scoreboard entry.
    always @(negedge clk) begin
        beat_t e;
        if (reset && out_ready && (sel64 ? v64 : v8)) begin
            if (exp_q.size() == 0) begin
                check_output("beat_unexpected", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                check_output("beat_data", sel64 ? o64 : {56'd0, o8}, e.data);
                check_output("burst_last", 64'(sel64 ? bl64 : bl8), 64'(e.last));
            end
        end
    end

    initial begin
        logic [63:0] s;
        logic [63:0] held;

        #1;
        check_output("rst_out", o64, 64'd0);
        check_output("rst_valid", 64'(v64), 64'd0);
        check_output("rst_last", 64'(bl64), 64'd0);
        check_output("rst_wc", 64'(wc64), 64'd0);
        check_output("rst_lockup", 64'(lk64), 64'd0);
        check_output("rst_valid8", 64'(v8), 64'd0);

        $display("[TB] full-period 8-bit RAW sequence");
        do_reset();
        sel64 = 1'b0;
        s = 64'h1;
        for (int i = 0; i < 255; i++) begin
            exp_q.push_back({s, 1'b0});
            s = adv8(s);
        end
        apply_stimulus(64'h1, RAW, 1'b1);
        begin
            int n = 0;
            while (exp_q.size() != 0 && n < 600) begin
                @(posedge clk);
                n++;
            end
        end
        #1;
        exp_q.push_back({64'h1, 1'b0});
        check_output("wc_255", 64'(wc8), 64'd255);
        drain(10);
        check_output("wc_256", 64'(wc8), 64'd256);

        $display("[TB] RAW backpressure");
        do_reset();
        sel64 = 1'b1;
        apply_stimulus(64'hDEAD_BEEF_0123_4567, RAW, 1'b0);
        wait_valid64(20);
        held = o64;
        check_output("stall_first", o64, 64'hDEAD_BEEF_0123_4567);
        repeat (5) begin
            @(negedge clk);
            check_output("stall_data", o64, held);
            check_output("stall_valid", 64'(v64), 64'd1);
            check_output("stall_wc", 64'(wc64), 64'd0);
        end
        s = 64'hDEAD_BEEF_0123_4567;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({s, 1'b0});
            s = adv64(s);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain(20);

        $display("[TB] BURST with pause and mode change");
        do_reset();
        s = 64'h0F0F_1234_5678_9ABC;
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back({s, (i % 8) == 7});
            s = adv64(s);
        end
        apply_stimulus(64'h0F0F_1234_5678_9ABC, BURST, 1'b1);
        wait_wc(32'd3, 50);
        enable = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_output("pause_valid", 64'(v64), 64'd0);
        enable = 1'b1;
        wait_wc(32'd5, 50);
        mode = WALK;
        @(posedge clk);
        #1 mode = BURST;
        drain(100);
        check_output("burst_wc", 64'(wc64), 64'd16);

        $display("[TB] ADDR masking");
        do_reset();
        addr_mask = 27'h00FFFF8;
        s = 64'h1357_9BDF_2468_ACE1;
        for (int i = 0; i < 1000; i++) begin
            exp_q.push_back({{37'd0, s[26:0] & 27'h00FFFF8}, 1'b0});
            s = adv64(s);
        end
        apply_stimulus(64'h1357_9BDF_2468_ACE1, ADDR, 1'b1);
        drain(3000);
        check_output("addr_wc", 64'(wc64), 64'd1000);
        addr_mask = '1;

        $display("[TB] WALK and reseed");
        do_reset();
        for (int i = 0; i < 64; i++) exp_q.push_back({64'd1 << i, 1'b0});
        exp_q.push_back({64'd1, 1'b0});
        apply_stimulus(64'h55, WALK, 1'b1);
        drain(200);
        exp_q.push_back({64'd2, 1'b0});
        @(posedge clk);
        #1 seed_load = 1'b1;
        @(posedge clk);
        #1 seed_load = 1'b0;
        exp_q.push_back({64'd1, 1'b0});
        exp_q.push_back({64'd2, 1'b0});
        exp_q.push_back({64'd4, 1'b0});
        out_ready = 1'b1;
        enable = 1'b1;
        drain(20);

        $display("[TB] zero seed");
        do_reset();
`ifdef LFSR_LOCKUP_DET_EN
        s = 64'h1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({s, 1'b0});
            s = adv64(s);
        end
        apply_stimulus(64'h0, RAW, 1'b1);
        drain(20);
        check_output("lockup_set", 64'(lk64), 64'd1);
`else
        for (int i = 0; i < 3; i++) exp_q.push_back({64'd0, 1'b0});
        apply_stimulus(64'h0, RAW, 1'b1);
        drain(20);
        check_output("lockup_tied", 64'(lk64), 64'd0);
`endif

        $display("[TB] reset mid-burst");
        do_reset();
        apply_stimulus(64'hABCD_0000_1111_2222, BURST, 1'b0);
        wait_valid64(20);
        reset = 1'b0;
        #1;
        check_output("async_valid", 64'(v64), 64'd0);
        check_output("async_out", o64, 64'd0);
        #10 reset = 1'b1;
        @(posedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
